// File: rtl/tile2048_pkg.sv
// Shared geometry, colour and tile-code widths for the 2048 tile renderer,
// the redraw scheduler and the display top.
package tile2048_pkg;
  localparam int TILE_SIZE  = 60;
  localparam int TILE_PITCH = 64;
  localparam int BOARD_X0   = 64;
  localparam int BOARD_Y0   = 112;
  localparam int FB_WIDTH   = 640;
  localparam int RGB_W      = 12;
  localparam int CODE_W     = 4;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WRITE, DONE} sched_state_t;
endpackage

// File: rtl/tile_redraw_scheduler_dirty_pick.sv
// Lowest-index-first priority encoder over the 16-tile dirty mask.
module dirty_pick (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        any
);
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--)
      if (mask[i]) idx = 4'(i);
  end

  assign any = |mask;
endmodule

// File: rtl/tile_redraw_scheduler.sv
// Walks dirty tiles of the 4x4 board through the external renderer and
// streams each tile's pixels to the framebuffer write port.
module tile_redraw_scheduler
  import tile2048_pkg::*;
#(
  parameter int TILE_SIZE  = tile2048_pkg::TILE_SIZE,
  parameter int TILE_PITCH = tile2048_pkg::TILE_PITCH,
  parameter int BOARD_X0   = tile2048_pkg::BOARD_X0,
  parameter int BOARD_Y0   = tile2048_pkg::BOARD_Y0,
  parameter int FB_WIDTH   = tile2048_pkg::FB_WIDTH,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              board_we,
  input  logic [3:0]        board_idx,
  input  logic [CODE_W-1:0] board_val,
  input  logic              redraw_all,
  output logic [CODE_W-1:0] tile_value,
  output logic [5:0]        tile_pos_x,
  output logic [5:0]        tile_pos_y,
  input  logic [RGB_W-1:0]  pixel_color,
  output logic              fb_wr_valid,
  input  logic              fb_wr_ready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [RGB_W-1:0]  fb_data,
  output logic              busy,
  output logic              tile_done,
  output logic              all_clean
);
  localparam logic [5:0]        LAST      = 6'(TILE_SIZE - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_WIDTH - TILE_SIZE + 1);

  sched_state_t             state;
  logic [15:0][CODE_W-1:0]  shadow;
  logic [15:0]              dirty, dirty_nxt;
  logic [3:0]               pick;
  logic                     pick_any;
  logic [5:0]               x, y;
  logic [ADDR_W-1:0]        base;

  dirty_pick u_pick (.mask(dirty), .idx(pick), .any(pick_any));

  // Sets are applied after the LOAD clear so a same-cycle update re-dirties the tile.
  always_comb begin
    dirty_nxt = dirty;
    if (state == LOAD) dirty_nxt[pick] = 1'b0;
    if (redraw_all)    dirty_nxt = '1;
    if (board_we)      dirty_nxt[board_idx] = 1'b1;
  end

  // Only place with multiplies; evaluated once per tile in LOAD.
  assign base = ADDR_W'((BOARD_Y0 + int'(pick[3:2]) * TILE_PITCH) * FB_WIDTH
                        + BOARD_X0 + int'(pick[1:0]) * TILE_PITCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shadow <= '0;
    else if (board_we) shadow[board_idx] <= board_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dirty       <= '1;
      tile_value  <= '0;
      x           <= '0;
      y           <= '0;
      fb_wr_valid <= 1'b0;
      fb_addr     <= '0;
      tile_done   <= 1'b0;
    end else begin
      dirty     <= dirty_nxt;
      tile_done <= 1'b0;
      case (state)
        IDLE: if (enable && pick_any) state <= LOAD;
        LOAD: begin
          tile_value <= shadow[pick];
          x          <= '0;
          y          <= '0;
          fb_addr    <= base;
          state      <= ISSUE;
        end
        ISSUE: begin
          fb_wr_valid <= 1'b1;
          state       <= WRITE;
        end
        WRITE: if (fb_wr_ready) begin
          fb_wr_valid <= 1'b0;
          if (x != LAST) begin
            x       <= x + 6'd1;
            fb_addr <= fb_addr + ADDR_W'(1);
            state   <= ISSUE;
          end else if (y != LAST) begin
            x       <= '0;
            y       <= y + 6'd1;
            fb_addr <= fb_addr + LINE_STEP;
            state   <= ISSUE;
          end else begin
            tile_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: state <= (enable && pick_any) ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign tile_pos_x = x;
  assign tile_pos_y = y;
  assign busy       = (state != IDLE);
  assign all_clean  = (state == IDLE) && (dirty == '0);
  // Renderer output is valid for the held coordinates throughout WRITE.
  assign fb_data    = fb_wr_valid ? pixel_color : '0;
endmodule

// File: tb/tb_tile_redraw_scheduler.sv
// Bench: small-tile instance with a scoreboard of expected framebuffer writes,
// plus a full-size instance for the real tile geometry and per-tile timing.
module tb_tile_redraw_scheduler;
  localparam int TS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;

  // small instance
  logic        rst_n = 1'b0, enable = 1'b0, board_we = 1'b0, redraw_all = 1'b0, ready = 1'b1;
  logic [3:0]  board_idx = '0, board_val = '0, tile_value;
  logic [5:0]  tile_pos_x, tile_pos_y;
  logic [11:0] pixel_color = '0, fb_data;
  logic [18:0] fb_addr;
  logic        fb_wr_valid, busy, tile_done, all_clean;

  tile_redraw_scheduler #(.TILE_SIZE(TS)) dut (
    .clk(clk), .reset_n(rst_n), .enable(enable), .board_we(board_we),
    .board_idx(board_idx), .board_val(board_val), .redraw_all(redraw_all),
    .tile_value(tile_value), .tile_pos_x(tile_pos_x), .tile_pos_y(tile_pos_y),
    .pixel_color(pixel_color), .fb_wr_valid(fb_wr_valid), .fb_wr_ready(ready),
    .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .tile_done(tile_done),
    .all_clean(all_clean));

  // full-size instance
  logic        rst_b = 1'b0, en_b = 1'b0;
  logic [3:0]  tv_b;
  logic [5:0]  px_b, py_b;
  logic [11:0] pix_b = '0, data_b;
  logic [18:0] addr_b;
  logic        valid_b, busy_b, done_b, clean_b;

  tile_redraw_scheduler dut_big (
    .clk(clk), .reset_n(rst_b), .enable(en_b), .board_we(1'b0),
    .board_idx(4'd0), .board_val(4'd0), .redraw_all(1'b0),
    .tile_value(tv_b), .tile_pos_x(px_b), .tile_pos_y(py_b),
    .pixel_color(pix_b), .fb_wr_valid(valid_b), .fb_wr_ready(1'b1),
    .fb_addr(addr_b), .fb_data(data_b), .busy(busy_b), .tile_done(done_b),
    .all_clean(clean_b));

  function automatic logic [11:0] pix(logic [3:0] v, logic [5:0] px, logic [5:0] py);
    return {v, px[3:0], py[3:0]};
  endfunction

  function automatic logic [18:0] exp_addr(int idx, int px, int py);
    int sx, sy;
    sx = 64 + (idx % 4) * 64 + px;
    sy = 112 + (idx / 4) * 64 + py;
    return 19'(sy * 640 + sx);
  endfunction

  // renderer models: one-cycle registered colour
  always @(posedge clk) begin
    pixel_color <= pix(tile_value, tile_pos_x, tile_pos_y);
    pix_b       <= pix(tv_b, px_b, py_b);
  end

  typedef struct { logic [18:0] addr; logic [11:0] data; } wr_t;
  wr_t sbq[$];
  int  acc_cnt = 0, done_cnt = 0;
  logic [18:0] first_addr = '0, last_addr = '0;
  logic [3:0]  shadow_m [16];

  task automatic push_tile(int idx, logic [3:0] v);
    for (int py = 0; py < TS; py++)
      for (int px = 0; px < TS; px++)
        sbq.push_back('{exp_addr(idx, px, py), pix(v, 6'(px), 6'(py))});
  endtask

  // scoreboard: each accepted write pops exactly one expected entry
  always @(negedge clk) begin
    if (rst_n && fb_wr_valid && ready) begin
      ncmp++;
      if (sbq.size() == 0) begin
        nfail++;
        $display("FAIL sb_extra: unexpected write addr=%0d data=%h", fb_addr, fb_data);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        if (fb_addr !== e.addr || fb_data !== e.data) begin
          nfail++;
          $display("FAIL sb_write: got addr=%0d data=%h want addr=%0d data=%h",
                   fb_addr, fb_data, e.addr, e.data);
        end
      end
      if (acc_cnt == 0) first_addr = fb_addr;
      last_addr = fb_addr;
      acc_cnt++;
    end
    if (rst_n && tile_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_tile(int idx, logic [3:0] v);
    tick();
    board_we = 1'b1; board_idx = 4'(idx); board_val = v; shadow_m[idx] = v;
    tick();
    board_we = 1'b0;
  endtask

  task automatic wait_clean(int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (all_clean) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_acc(int n, int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (acc_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    ncmp++; if (fb_wr_valid !== 1'b0 || fb_addr !== '0 || fb_data !== '0) begin
      nfail++; $display("FAIL reset_fb: valid=%b addr=%0d data=%h want 0", fb_wr_valid, fb_addr, fb_data); end
    ncmp++; if (busy !== 1'b0 || tile_done !== 1'b0 || all_clean !== 1'b0) begin
      nfail++; $display("FAIL reset_status: busy=%b done=%b clean=%b want 0 0 0", busy, tile_done, all_clean); end
    ncmp++; if (tile_value !== '0 || tile_pos_x !== '0 || tile_pos_y !== '0) begin
      nfail++; $display("FAIL reset_coord: v=%0d x=%0d y=%0d want 0", tile_value, tile_pos_x, tile_pos_y); end
    tick();
    rst_n = 1'b1; rst_b = 1'b1;
    repeat (3) tick();
    ncmp++; if (busy !== 1'b0) begin
      nfail++; $display("FAIL reset_hold_idle: busy=%b want 0 with enable low", busy); end
  endtask

  task automatic test_full_size();
    int cyc = 0;
    bit ok = 1'b0, seen = 1'b0;
    logic [18:0] fa = '0, la = '0;
    en_b = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (busy_b) cyc++;
      if (valid_b) begin
        if (!seen) fa = addr_b;
        seen = 1'b1; la = addr_b;
      end
      if (done_b) begin ok = 1'b1; break; end
    end
    tick();
    en_b = 1'b0;
    ncmp++; if (!ok) begin nfail++; $display("FAIL big_timeout: no tile_done within 8000 cycles"); end
    ncmp++; if (cyc != 7202) begin nfail++; $display("FAIL big_cycles: got %0d want 7202", cyc); end
    ncmp++; if (fa !== 19'd71744) begin nfail++; $display("FAIL big_first_addr: got %0d want 71744", fa); end
    ncmp++; if (la !== 19'd109563) begin nfail++; $display("FAIL big_last_addr: got %0d want 109563", la); end
  endtask

  task automatic test_full_redraw();
    int last = -1, bad = 0;
    bit ok = 1'b0;
    acc_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 16; i++) begin shadow_m[i] = '0; push_tile(i, 4'd0); end
    tick();
    enable = 1'b1;
    for (int c = 0; c < 16 * 140; c++) begin
      @(negedge clk);
      if (tile_done) begin
        if (last >= 0 && c - last != 2 + 2 * TS * TS) bad++;
        last = c;
      end
      if (all_clean) begin ok = 1'b1; break; end
    end
    ncmp++; if (!ok) begin nfail++; $display("FAIL full_timeout: all_clean never rose"); end
    ncmp++; if (bad != 0) begin nfail++; $display("FAIL full_tile_period: %0d bad intervals want 0", bad); end
    ncmp++; if (done_cnt != 16) begin nfail++; $display("FAIL full_done_cnt: got %0d want 16", done_cnt); end
    ncmp++; if (first_addr !== 19'd71744) begin nfail++; $display("FAIL full_first_addr: got %0d want 71744", first_addr); end
    ncmp++; if (last_addr !== exp_addr(15, TS - 1, TS - 1)) begin
      nfail++; $display("FAIL full_last_addr: got %0d want %0d", last_addr, exp_addr(15, TS - 1, TS - 1)); end
    ncmp++; if (sbq.size() != 0) begin nfail++; $display("FAIL full_leftover: %0d writes missing", sbq.size()); end
  endtask

  task automatic test_single_update();
    bit ok;
    acc_cnt = 0; done_cnt = 0;
    push_tile(6, 4'd3);
    write_tile(6, 4'd3);
    wait_clean(400, ok);
    ncmp++; if (!ok) begin nfail++; $display("FAIL single_timeout: all_clean never rose"); end
    ncmp++; if (first_addr !== 19'd112832) begin nfail++; $display("FAIL single_first_addr: got %0d want 112832", first_addr); end
    ncmp++; if (acc_cnt != TS * TS || done_cnt != 1) begin
      nfail++; $display("FAIL single_counts: writes=%0d done=%0d want %0d 1", acc_cnt, done_cnt, TS * TS); end
  endtask

  task automatic test_mid_update();
    bit ok;
    acc_cnt = 0; done_cnt = 0;
    push_tile(9, 4'd2);
    write_tile(9, 4'd2);
    wait_acc(20, 200, ok);
    ncmp++; if (!ok) begin nfail++; $display("FAIL mid_start: tile 9 never started"); end
    push_tile(9, 4'd5);
    write_tile(9, 4'd5);
    wait_clean(600, ok);
    ncmp++; if (!ok || done_cnt != 2 || sbq.size() != 0) begin
      nfail++; $display("FAIL mid_redraw: clean=%b done=%0d left=%0d want 1 2 0", ok, done_cnt, sbq.size()); end
  endtask

  task automatic test_load_collision();
    bit ok;
    tick();
    enable = 1'b0;
    write_tile(3, 4'd1);
    done_cnt = 0;
    push_tile(3, 4'd1);
    push_tile(3, 4'd7);
    tick();
    enable = 1'b1;
    tick();
    board_we = 1'b1; board_idx = 4'd3; board_val = 4'd7; shadow_m[3] = 4'd7;
    tick();
    board_we = 1'b0;
    wait_clean(600, ok);
    ncmp++; if (!ok || done_cnt != 2 || sbq.size() != 0) begin
      nfail++; $display("FAIL load_collision: clean=%b done=%0d left=%0d want 1 2 0", ok, done_cnt, sbq.size()); end
  endtask

  task automatic test_stall();
    bit ok = 1'b0;
    int bad = 0;
    acc_cnt = 0;
    push_tile(0, 4'd4);
    write_tile(0, 4'd4);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy && !fb_wr_valid && tile_pos_x == 6'd5 && tile_pos_y == 6'd5) begin ok = 1'b1; break; end
    end
    ncmp++; if (!ok) begin nfail++; $display("FAIL stall_reach: pixel (5,5) never issued"); end
    tick();
    ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ncmp++;
      if (fb_wr_valid !== 1'b1 || fb_addr !== exp_addr(0, 5, 5) || fb_data !== pix(4'd4, 6'd5, 6'd5)) begin
        nfail++; bad++;
        $display("FAIL stall_hold: cyc=%0d valid=%b addr=%0d data=%h want 1 %0d %h",
                 k, fb_wr_valid, fb_addr, fb_data, exp_addr(0, 5, 5), pix(4'd4, 6'd5, 6'd5));
      end
    end
    tick();
    ready = 1'b1;
    wait_clean(400, ok);
    ncmp++; if (!ok || acc_cnt != TS * TS || sbq.size() != 0) begin
      nfail++; $display("FAIL stall_total: clean=%b writes=%0d left=%0d want 1 %0d 0", ok, acc_cnt, sbq.size(), TS * TS); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    tick();
    enable = 1'b0;
    tick();
    redraw_all = 1'b1;
    tick();
    redraw_all = 1'b0;
    for (int i = 0; i < 16; i++) push_tile(i, shadow_m[i]);
    acc_cnt = 0; done_cnt = 0;
    tick();
    enable = 1'b1;
    wait_acc(10, 200, ok);
    tick();
    enable = 1'b0;
    for (int c = 0; c < 300 && done_cnt == 0; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    ncmp++; if (busy !== 1'b0 || all_clean !== 1'b0) begin
      nfail++; $display("FAIL drop_idle: busy=%b clean=%b want 0 0", busy, all_clean); end
    ncmp++; if (done_cnt != 1 || acc_cnt != TS * TS) begin
      nfail++; $display("FAIL drop_counts: done=%0d writes=%0d want 1 %0d", done_cnt, acc_cnt, TS * TS); end
    tick();
    enable = 1'b1;
    wait_clean(16 * 140, ok);
    ncmp++; if (!ok || done_cnt != 16 || sbq.size() != 0) begin
      nfail++; $display("FAIL drop_resume: clean=%b done=%0d left=%0d want 1 16 0", ok, done_cnt, sbq.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    tick();
    redraw_all = 1'b1;
    tick();
    redraw_all = 1'b0;
    for (int i = 0; i < 16; i++) push_tile(i, shadow_m[i]);
    acc_cnt = 0;
    wait_acc(30, 200, ok);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    ncmp++; if (fb_wr_valid !== 1'b0 || fb_addr !== '0 || fb_data !== '0) begin
      nfail++; $display("FAIL rstmid_fb: valid=%b addr=%0d data=%h want 0", fb_wr_valid, fb_addr, fb_data); end
    ncmp++; if (busy !== 1'b0 || tile_value !== '0 || tile_pos_x !== '0 || tile_pos_y !== '0) begin
      nfail++; $display("FAIL rstmid_state: busy=%b v=%0d x=%0d y=%0d want 0", busy, tile_value, tile_pos_x, tile_pos_y); end
    sbq.delete();
    for (int i = 0; i < 16; i++) begin shadow_m[i] = '0; push_tile(i, 4'd0); end
    acc_cnt = 0; done_cnt = 0;
    tick();
    rst_n = 1'b1;
    wait_clean(16 * 140, ok);
    ncmp++; if (!ok || done_cnt != 16 || first_addr !== 19'd71744 || sbq.size() != 0) begin
      nfail++; $display("FAIL rstmid_redraw: clean=%b done=%0d first=%0d left=%0d want 1 16 71744 0",
                        ok, done_cnt, first_addr, sbq.size()); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow_m[i] = '0;
    test_reset();
    test_full_size();
    test_full_redraw();
    test_single_update();
    test_mid_update();
    test_load_collision();
    test_stall();
    test_enable_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
